// File: rtl/mcu_block_scheduler.sv
// mcu_block_scheduler: grants whole 8x8 blocks from the Y, Cb and Cr block
// streams to a single DCT input port in JPEG MCU order (4:2:0 or 4:4:4),
// counting blocks and MCUs and flagging MCU and image completion.
module mcu_block_scheduler #(
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int BLOCK_BEATS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mode_420,
    input  logic [7:0] y_data,
    input  logic       y_valid,
    output logic       y_ready,
    input  logic [7:0] cb_data,
    input  logic       cb_valid,
    output logic       cb_ready,
    input  logic [7:0] cr_data,
    input  logic       cr_valid,
    output logic       cr_ready,
    output logic [7:0] dct_data,
    output logic       dct_valid,
    input  logic       dct_ready,
    output logic [1:0] dct_comp,
    output logic       dct_first,
    output logic       dct_last,
    output logic       mcu_done,
    output logic       img_done,
    output logic       busy
);

    localparam int MCUS_420 = (IMG_WIDTH / 16) * (IMG_HEIGHT / 16);
    localparam int MCUS_444 = (IMG_WIDTH / 8) * (IMG_HEIGHT / 8);
    localparam int MCU_W    = $clog2(MCUS_444 + 1);
    localparam int BEAT_W   = $clog2(BLOCK_BEATS);

    localparam logic [MCU_W-1:0]  TOTAL_420 = MCU_W'(MCUS_420);
    localparam logic [MCU_W-1:0]  TOTAL_444 = MCU_W'(MCUS_444);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [1:0] {COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2} comp_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [MCU_W-1:0]  total_q, total_d;
    logic [MCU_W-1:0]  mcu_q, mcu_d;
    logic [2:0]        slot_q, slot_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              mcu_done_q, mcu_done_d;

    comp_e      comp;
    logic [2:0] last_slot;
    logic       xfer;

    // Slot table: which component owns the current slot, and where the MCU ends.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        comp      = COMP_Y;
        last_slot = mode_q ? 3'd5 : 3'd2;
        if (mode_q) begin
            if (slot_q == 3'd4)      comp = COMP_CB;
            else if (slot_q == 3'd5) comp = COMP_CR;
        end else begin
            if (slot_q == 3'd1)      comp = COMP_CB;
            else if (slot_q == 3'd2) comp = COMP_CR;
        end
    end

    // Zero-latency data mux: only the granted stream sees dct_ready, and only in RUN.
    always_comb begin
        dct_data  = 8'd0;
        dct_valid = 1'b0;
        dct_comp  = 2'd0;
        dct_first = 1'b0;
        dct_last  = 1'b0;
        y_ready   = 1'b0;
        cb_ready  = 1'b0;
        cr_ready  = 1'b0;
        if (state_q == ST_RUN) begin
            dct_comp  = comp;
            dct_first = (beat_q == '0);
            dct_last  = (beat_q == BEAT_LAST);
            unique case (comp)
                COMP_CB: begin
                    dct_data  = cb_data;
                    dct_valid = cb_valid;
                    cb_ready  = dct_ready;
                end
                COMP_CR: begin
                    dct_data  = cr_data;
                    dct_valid = cr_valid;
                    cr_ready  = dct_ready;
                end
                default: begin
                    dct_data  = y_data;
                    dct_valid = y_valid;
                    y_ready   = dct_ready;
                end
            endcase
        end
    end

    assign xfer = dct_valid && dct_ready;

    // Next-state logic: beat/slot/MCU counters advance only on a transfer; abort wins over all.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        total_d    = total_q;
        mcu_d      = mcu_q;
        slot_d     = slot_q;
        beat_d     = beat_q;
        mcu_done_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            mcu_d   = '0;
            slot_d  = '0;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        mode_d  = mode_420;
                        total_d = mode_420 ? TOTAL_420 : TOTAL_444;
                        mcu_d   = '0;
                        slot_d  = '0;
                        beat_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (beat_q == BEAT_LAST) begin
                            beat_d = '0;
                            if (slot_q == last_slot) begin
                                slot_d     = '0;
                                mcu_done_d = 1'b1;
                                mcu_d      = mcu_q + MCU_W'(1);
                                if (mcu_q == total_q - MCU_W'(1)) state_d = ST_DONE;
                            end else begin
                                slot_d = slot_q + 3'd1;
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            total_q    <= '0;
            mcu_q      <= '0;
            slot_q     <= '0;
            beat_q     <= '0;
            mcu_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            mode_q     <= mode_d;
            total_q    <= total_d;
            mcu_q      <= mcu_d;
            slot_q     <= slot_d;
            beat_q     <= beat_d;
            mcu_done_q <= mcu_done_d;
        end
    end

    assign mcu_done = mcu_done_q;
    assign img_done = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// tb_mcu_block_scheduler: scoreboard bench; the expected beat sequence of an
// image is built from the MCU order and the stream counters at start, and each
// DCT transfer pops and compares the head.
module tb_mcu_block_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, mode_420;
    logic [7:0] y_data, cb_data, cr_data, dct_data;
    logic       y_valid, cb_valid, cr_valid, y_ready, cb_ready, cr_ready;
    logic       dct_valid, dct_ready, dct_first, dct_last, mcu_done, img_done, busy;
    logic [1:0] dct_comp;

    typedef struct {
        logic [1:0] comp;
        logic [7:0] data;
        logic       first;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    y_cnt = 0, cb_cnt = 0, cr_cnt = 0;

    mcu_block_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_420(mode_420),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .cb_data(cb_data), .cb_valid(cb_valid), .cb_ready(cb_ready),
        .cr_data(cr_data), .cr_valid(cr_valid), .cr_ready(cr_ready),
        .dct_data(dct_data), .dct_valid(dct_valid), .dct_ready(dct_ready),
        .dct_comp(dct_comp), .dct_first(dct_first), .dct_last(dct_last),
        .mcu_done(mcu_done), .img_done(img_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // All outputs must sit at their reset/idle values.
    task automatic check_quiet(input string tag);
        check({tag, "_y_ready"},   32'(y_ready),   0);
        check({tag, "_cb_ready"},  32'(cb_ready),  0);
        check({tag, "_cr_ready"},  32'(cr_ready),  0);
        check({tag, "_dct_valid"}, 32'(dct_valid), 0);
        check({tag, "_dct_data"},  32'(dct_data),  0);
        check({tag, "_dct_comp"},  32'(dct_comp),  0);
        check({tag, "_dct_first"}, 32'(dct_first), 0);
        check({tag, "_dct_last"},  32'(dct_last),  0);
        check({tag, "_mcu_done"},  32'(mcu_done),  0);
        check({tag, "_img_done"},  32'(img_done),  0);
        check({tag, "_busy"},      32'(busy),      0);
    endtask

    // Runs one image. abort_at/start_at/reset_at < 0 disable that disturbance.
    task automatic run_image(input bit m420, input bit bp, input bit starve,
                             input int abort_at, input int start_at, input int reset_at);
        int    mcus, slots, total, exp_done, xfers, mcu_seen, img_seen, done_at;
        int    yc, cbc, crc, starve_left, c;
        bit    starved, finished;
        beat_t e;
        mcus  = m420 ? 16 : 64;
        slots = m420 ? 6 : 3;
        total = mcus * slots * 64;
        exp_done = (bp ? 2 * total : total + 1) + (starve ? 100 : 0);
        sb.delete();
        yc = y_cnt; cbc = cb_cnt; crc = cr_cnt;
        for (int m = 0; m < mcus; m++)
            for (int s = 0; s < slots; s++) begin
                c = m420 ? ((s < 4) ? 0 : s - 3) : s;
                for (int b = 0; b < 64; b++) begin
                    e.comp  = 2'(c);
                    e.first = (b == 0);
                    e.last  = (b == 63);
                    if (c == 0)      begin e.data = 8'(yc);  yc++;  end
                    else if (c == 1) begin e.data = 8'(cbc); cbc++; end
                    else             begin e.data = 8'(crc); crc++; end
                    sb.push_back(e);
                end
            end
        xfers = 0; mcu_seen = 0; img_seen = 0; done_at = 0;
        starve_left = 0; starved = 0; finished = 0;

        @(negedge clk);
        check("idle_before_start", 32'(busy), 0);
        mode_420 = m420; start = 1'b1; abort = 1'b0; dct_ready = 1'b1;

        for (int n = 1; n <= 40000; n++) begin
            @(negedge clk);
            start    = (n == start_at);
            mode_420 = !m420;
            if (starve && !starved && sb.size() > 0 && sb[0].comp == 2'd1 && sb[0].first) begin
                starve_left = 100;
                starved     = 1;
            end
            y_valid  = 1'b1;
            cr_valid = 1'b1;
            cb_valid = (starve_left == 0);
            y_data   = 8'(y_cnt);
            cb_data  = 8'(cb_cnt);
            cr_data  = 8'(cr_cnt);
            dct_ready = bp ? n[0] : 1'b1;
            abort = (abort_at >= 0 && xfers == abort_at);
            if (abort) dct_ready = 1'b0;
            #1;
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet("async_reset");
                @(negedge clk);
                check_quiet("held_reset");
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            if (starve_left > 0) begin
                check("starve_y_ready",   32'(y_ready),   0);
                check("starve_cr_ready",  32'(cr_ready),  0);
                check("starve_dct_valid", 32'(dct_valid), 0);
                starve_left--;
            end
            if (dct_valid && dct_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data",  32'(dct_data),  32'(e.data));
                    check("comp",  32'(dct_comp),  32'(e.comp));
                    check("first", 32'(dct_first), 32'(e.first));
                    check("last",  32'(dct_last),  32'(e.last));
                end
                xfers++;
            end else if (dct_valid && sb.size() > 0) begin
                check("hold_data", 32'(dct_data), 32'(sb[0].data));
                check("hold_comp", 32'(dct_comp), 32'(sb[0].comp));
                check("hold_last", 32'(dct_last), 32'(sb[0].last));
            end
            if (y_valid && y_ready)   y_cnt++;
            if (cb_valid && cb_ready) cb_cnt++;
            if (cr_valid && cr_ready) cr_cnt++;
            if (mcu_done) mcu_seen++;
            if (abort) begin
                @(negedge clk);
                abort = 1'b0;
                dct_ready = 1'b1;
                #1;
                check_quiet("after_abort");
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    #1;
                    check("abort_img_done", 32'(img_done), 0);
                    check("abort_mcu_done", 32'(mcu_done), 0);
                end
                return;
            end
            if (img_done) begin
                img_seen++;
                done_at  = n;
                finished = 1;
                break;
            end
        end

        check("finished_in_budget", 32'(finished), 1);
        check("img_done_cycle", done_at, exp_done);
        check("transfers", xfers, total);
        check("mcu_done_count", mcu_seen, mcus);
        check("img_done_count", img_seen, 1);
        check("scoreboard_empty", sb.size(), 0);
        @(negedge clk);
        #1;
        check("idle_after_done_busy", 32'(busy), 0);
        check("idle_after_done_img",  32'(img_done), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_420 = 1'b0; dct_ready = 1'b0;
        y_data = 8'd0; cb_data = 8'd0; cr_data = 8'd0;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        #1;
        check_quiet("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_image(1'b1, 1'b0, 1'b0, -1, -1, -1);   // 4:2:0 full rate
        run_image(1'b0, 1'b0, 1'b0, -1, -1, -1);   // 4:4:4 full rate
        run_image(1'b1, 1'b1, 1'b0, -1, -1, -1);   // dct_ready toggling
        run_image(1'b1, 1'b0, 1'b1, -1, -1, -1);   // Cb starved at slot 4
        run_image(1'b1, 1'b0, 1'b0, 3 * 384 + 2 * 64 + 17, -1, -1);  // abort mid-block
        run_image(1'b1, 1'b0, 1'b0, -1, -1, -1);   // clean image after abort
        run_image(1'b1, 1'b0, 1'b0, -1, 300, 700); // start while busy, then reset
        run_image(1'b0, 1'b0, 1'b0, -1, -1, -1);   // clean image after reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
